// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-decoder definitions: DC category limits, decoder states
// and a reference EXTEND helper usable from any coefficient path.
package jpeg_pkg;

    localparam int DC_MAX_SIZE = 11;
    localparam int JPEG_DC_W   = 12;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } dec_state_t;

    // v holds the s magnitude bits right-aligned; a clear leading bit marks a negative value
    function automatic logic signed [JPEG_DC_W-1:0] extend(
        input logic [JPEG_DC_W-1:0] v,
        input logic [4:0]           s
    );
        logic [JPEG_DC_W-1:0] mask;
        logic [JPEG_DC_W-1:0] top;
        mask = ~({JPEG_DC_W{1'b1}} << s);
        top  = (s == 5'd0) ? '0 : ({{(JPEG_DC_W-1){1'b0}}, 1'b1} << (s - 5'd1));
        if (s == 5'd0) begin
            return '0;
        end else if ((v & top) == '0) begin
            return (v & mask) - mask;
        end else begin
            return v & mask;
        end
    endfunction

endpackage

// File: rtl/dc_extend.sv
// Combinational JPEG EXTEND: turns s raw magnitude bits into a signed value
// sign-extended to DC_W bits. Shared by the DC and AC coefficient paths.
module dc_extend #(
    parameter int DC_W = 12
) (
    input  logic [DC_W-1:0] v,
    input  logic [4:0]      size,
    output logic [DC_W-1:0] diff
);

    logic [DC_W-1:0] mask;
    logic [DC_W-1:0] top;

    always_comb begin
        mask = ~({DC_W{1'b1}} << size);
        top  = (size == 5'd0) ? '0 : ({{(DC_W-1){1'b0}}, 1'b1} << (size - 5'd1));
        diff = '0;
        // v - (2^s - 1) is exactly v - mask once v is confined to s bits
        if (size != 5'd0) begin
            if ((v & top) == '0) begin
                diff = (v & mask) - mask;
            end else begin
                diff = v & mask;
            end
        end
    end

endmodule

// File: rtl/huffman_dc_diff_decoder.sv
// DC difference decoder: pulls size magnitude bits per DC category, applies
// EXTEND and accumulates into per-component predictors.
//   state | meaning
//   IDLE  | waiting for a DC category from the Huffman lookup
//   READ  | shifting in the remaining magnitude bits of the current category
module huffman_dc_diff_decoder
    import jpeg_pkg::*;
#(
    parameter int NUM_COMP = 3,
    parameter int DC_W     = 12
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            size_valid_in,
    input  logic [4:0]      size_in,
    input  logic [1:0]      comp_in,
    output logic            size_ready_out,
    input  logic            bit_valid_in,
    input  logic            bit_in,
    output logic            bit_ready_out,
    input  logic            pred_clear_in,
    output logic            dc_valid_out,
    output logic [DC_W-1:0] dc_out,
    output logic [DC_W-1:0] diff_out,
    output logic            err_out
);

    dec_state_t state, state_nx;

    logic [3:0]             bit_cnt;
    logic [DC_MAX_SIZE-2:0] shift_q;
    logic [DC_MAX_SIZE-1:0] shifted;
    logic [4:0]             size_q;
    logic [1:0]             comp_q;
    logic [1:0]             comp_sel;
    logic [DC_W-1:0]        pred [NUM_COMP];
    logic [DC_W-1:0]        pred_sel;
    logic [DC_W-1:0]        ext_diff;
    logic [DC_W-1:0]        dc_sum;

    logic size_acc, size_bad, size_zero, size_start;
    logic bit_take, bit_last;

    assign size_ready_out = (state == IDLE) && !rst_in;
    assign bit_ready_out  = (state == READ);

    assign size_acc   = size_valid_in && (state == IDLE);
    assign size_bad   = (size_in > 5'(DC_MAX_SIZE)) || (32'(comp_in) >= NUM_COMP);
    assign size_zero  = size_acc && !size_bad && (size_in == 5'd0);
    assign size_start = size_acc && !size_bad && (size_in != 5'd0);

    assign bit_take = (state == READ) && bit_valid_in;
    assign bit_last = bit_take && (bit_cnt == 4'd1);

    // The final bit joins the word combinationally so the result lands one edge after it
    assign shifted  = {shift_q, bit_in};
    assign comp_sel = (state == READ) ? comp_q : comp_in;

    always_comb begin
        pred_sel = '0;
        for (int i = 0; i < NUM_COMP; i++) begin
            if (comp_sel == 2'(i)) begin
                pred_sel = pred[i];
            end
        end
    end

    dc_extend #(.DC_W(DC_W)) u_extend (
        .v    ({{(DC_W-DC_MAX_SIZE){1'b0}}, shifted}),
        .size (size_q),
        .diff (ext_diff)
    );

    assign dc_sum = pred_sel + ext_diff;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (size_start) state_nx = READ;
            READ:    if (bit_last)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt <= '0;
            shift_q <= '0;
            size_q  <= '0;
            comp_q  <= '0;
        end else if (size_start) begin
            bit_cnt <= size_in[3:0];
            shift_q <= '0;
            size_q  <= size_in;
            comp_q  <= comp_in;
        end else if (bit_take) begin
            bit_cnt <= bit_cnt - 4'd1;
            shift_q <= shifted[DC_MAX_SIZE-2:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dc_valid_out <= 1'b0;
            err_out      <= 1'b0;
            dc_out       <= '0;
            diff_out     <= '0;
        end else begin
            dc_valid_out <= size_zero || bit_last;
            err_out      <= size_acc && size_bad;
            if (size_zero) begin
                dc_out   <= pred_sel;
                diff_out <= '0;
            end else if (bit_last) begin
                dc_out   <= dc_sum;
                diff_out <= ext_diff;
            end
        end
    end

    // A restart clear overrides a same-edge predictor update
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_COMP; i++) begin
                if (pred_clear_in) begin
                    pred[i] <= '0;
                end else if (bit_last && (comp_q == 2'(i))) begin
                    pred[i] <= dc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_dc_diff_decoder.sv
// Bench for huffman_dc_diff_decoder: directed scenarios followed by random
// categories, compared against an integer model of EXTEND and the predictors.
module tb_huffman_dc_diff_decoder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        size_valid_in;
    logic [4:0]  size_in;
    logic [1:0]  comp_in;
    logic        size_ready_out;
    logic        bit_valid_in;
    logic        bit_in;
    logic        bit_ready_out;
    logic        pred_clear_in;
    logic        dc_valid_out;
    logic [11:0] dc_out;
    logic [11:0] diff_out;
    logic        err_out;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pred_m [3];
    logic [11:0] last_dc;

    huffman_dc_diff_decoder #(.NUM_COMP(3), .DC_W(12)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .size_valid_in  (size_valid_in),
        .size_in        (size_in),
        .comp_in        (comp_in),
        .size_ready_out (size_ready_out),
        .bit_valid_in   (bit_valid_in),
        .bit_in         (bit_in),
        .bit_ready_out  (bit_ready_out),
        .pred_clear_in  (pred_clear_in),
        .dc_valid_out   (dc_valid_out),
        .dc_out         (dc_out),
        .diff_out       (diff_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int extend_ref(input int v, input int s);
        if (s == 0) return 0;
        if (v < (1 << (s - 1))) return v - ((1 << s) - 1);
        return v;
    endfunction

    // One category plus its bits; checks the result pulse against the model
    task automatic decode(input int c, input int s, input int v, input bit gaps, input bit clr_last);
        int h;
        int diff;
        logic [11:0] e_dc;
        size_valid_in = 1'b1;
        size_in       = 5'(s);
        comp_in       = 2'(c);
        tick();
        h = cyc;
        size_valid_in = 1'b0;
        for (int i = s - 1; i >= 0; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bit_valid_in  = 1'b0;
                    bit_in        = 1'($urandom);
                    size_valid_in = 1'b1;
                    size_in       = 5'd0;
                    comp_in       = 2'd0;
                    tick();
                    chk("stall_no_pulse", {31'd0, dc_valid_out}, 32'd0);
                    chk("stall_size_ready_low", {31'd0, size_ready_out}, 32'd0);
                    size_valid_in = 1'b0;
                end
            end
            chk("bit_ready_in_read", {31'd0, bit_ready_out}, 32'd1);
            bit_valid_in  = 1'b1;
            bit_in        = 1'((v >> i) & 1);
            pred_clear_in = (i == 0) && clr_last;
            tick();
            bit_valid_in  = 1'b0;
            pred_clear_in = 1'b0;
            if (i != 0) chk("early_pulse", {31'd0, dc_valid_out}, 32'd0);
        end
        diff = extend_ref(v, s);
        e_dc = 12'(pred_m[c] + diff);
        chk("dc_valid", {31'd0, dc_valid_out}, 32'd1);
        chk("dc_out", {20'd0, dc_out}, {20'd0, e_dc});
        chk("diff_out", {20'd0, diff_out}, {20'd0, 12'(diff)});
        chk("err_quiet", {31'd0, err_out}, 32'd0);
        chk("ready_with_pulse", {31'd0, size_ready_out}, 32'd1);
        if (!gaps) chk("latency", 32'(cyc - h + 1), 32'((s == 0) ? 1 : s + 1));
        pred_m[c] = int'($signed(e_dc));
        if (clr_last) for (int k = 0; k < 3; k++) pred_m[k] = 0;
        last_dc = e_dc;
        // Idle cycle with a stray stream bit that must be ignored
        bit_valid_in = 1'b1;
        bit_in       = 1'($urandom);
        tick();
        bit_valid_in = 1'b0;
        chk("pulse_one_cycle", {31'd0, dc_valid_out}, 32'd0);
        chk("dc_hold", {20'd0, dc_out}, {20'd0, last_dc});
    endtask

    task automatic bad_size(input int c, input int s);
        size_valid_in = 1'b1;
        size_in       = 5'(s);
        comp_in       = 2'(c);
        tick();
        size_valid_in = 1'b0;
        chk("err_pulse", {31'd0, err_out}, 32'd1);
        chk("err_no_dc", {31'd0, dc_valid_out}, 32'd0);
        chk("err_dc_hold", {20'd0, dc_out}, {20'd0, last_dc});
        tick();
        chk("err_one_cycle", {31'd0, err_out}, 32'd0);
        chk("err_stays_idle", {31'd0, size_ready_out}, 32'd1);
    endtask

    initial begin
        int c, s, v;
        rst_in = 1'b1;
        size_valid_in = 1'b0; size_in = '0; comp_in = '0;
        bit_valid_in = 1'b0; bit_in = 1'b0; pred_clear_in = 1'b0;
        for (int k = 0; k < 3; k++) pred_m[k] = 0;
        last_dc = '0;
        #12;
        chk("rst_dc_valid", {31'd0, dc_valid_out}, 32'd0);
        chk("rst_dc_out", {20'd0, dc_out}, 32'd0);
        chk("rst_bit_ready", {31'd0, bit_ready_out}, 32'd0);
        chk("rst_err", {31'd0, err_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();
        chk("rel_size_ready", {31'd0, size_ready_out}, 32'd1);

        // Basic positive then negative difference on comp0
        decode(0, 3, 5, 1'b0, 1'b0);
        decode(0, 3, 2, 1'b0, 1'b0);

        // Zero category, including back-to-back acceptance
        decode(1, 2, 3, 1'b0, 1'b0);
        size_valid_in = 1'b1; size_in = 5'd0; comp_in = 2'd1;
        tick();
        chk("b2b_first_valid", {31'd0, dc_valid_out}, 32'd1);
        chk("b2b_first_dc", {20'd0, dc_out}, 32'(12'(pred_m[1])));
        tick();
        size_valid_in = 1'b0;
        chk("b2b_second_valid", {31'd0, dc_valid_out}, 32'd1);
        chk("b2b_second_diff", {20'd0, diff_out}, 32'd0);
        tick();
        chk("b2b_done", {31'd0, dc_valid_out}, 32'd0);
        decode(0, 0, 0, 1'b0, 1'b0);

        // Full-width category and wraparound, second pass with stalls
        decode(2, 11, 2047, 1'b0, 1'b0);
        decode(2, 11, 2047, 1'b1, 1'b0);
        chk("wrap_value", {20'd0, dc_out}, 32'hFFE);

        // Illegal categories and components
        bad_size(0, 12);
        bad_size(3, 2);
        bad_size(1, 31);
        decode(2, 0, 0, 1'b0, 1'b0);

        // Restart clear on the same edge as a result
        decode(0, 3, 5, 1'b0, 1'b0);
        decode(0, 2, 3, 1'b0, 1'b1);
        chk("clear_edge_dc", {20'd0, last_dc}, 32'd8);
        decode(0, 0, 0, 1'b0, 1'b0);
        decode(2, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a read
        decode(1, 4, 13, 1'b0, 1'b0);
        size_valid_in = 1'b1; size_in = 5'd5; comp_in = 2'd1;
        tick();
        size_valid_in = 1'b0;
        repeat (2) begin
            bit_valid_in = 1'b1; bit_in = 1'b1;
            tick();
        end
        bit_valid_in = 1'b0;
        rst_in = 1'b1;
        #1;
        chk("midrst_bit_ready", {31'd0, bit_ready_out}, 32'd0);
        chk("midrst_dc_out", {20'd0, dc_out}, 32'd0);
        chk("midrst_dc_valid", {31'd0, dc_valid_out}, 32'd0);
        tick();
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 3; k++) pred_m[k] = 0;
        last_dc = '0;
        tick();
        chk("midrst_idle", {31'd0, size_ready_out}, 32'd1);
        decode(0, 1, 0, 1'b0, 1'b0);
        chk("midrst_minus_one", {20'd0, dc_out}, 32'hFFF);
        decode(1, 0, 0, 1'b0, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            c = int'($urandom_range(0, 2));
            s = int'($urandom_range(0, 11));
            v = (s == 0) ? 0 : int'($urandom_range(0, (1 << s) - 1));
            if ($urandom_range(0, 9) == 0) begin
                bad_size(int'($urandom_range(0, 3)), 12 + int'($urandom_range(0, 19)));
            end else if ($urandom_range(0, 14) == 0) begin
                pred_clear_in = 1'b1;
                tick();
                pred_clear_in = 1'b0;
                for (int k = 0; k < 3; k++) pred_m[k] = 0;
            end else begin
                decode(c, s, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            end
        end
        for (int k = 0; k < 3; k++) decode(k, 0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
